// File: rtl/button_repeat.sv
// Push-button conditioner: two-flop synchroniser, tick-based debounce and
// auto-repeat, producing one-cycle count-enable pulses for time-set counters.
module button_repeat #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100,
    parameter int REPEAT_EN      = 1,
    parameter int CNT_WIDTH      = 10
) (
    input  logic i_sysclk,
    input  logic i_reset_n,
    input  logic i_tick_en,
    input  logic i_button,
    output logic o_pressed,
    output logic o_press,
    output logic o_release
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HOLD,
        REPEAT,
        DEB_RELEASE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEB_LAST   = CNT_WIDTH'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic                 btn_meta;
    logic                 btn_s;
    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 press_nxt;
    logic                 release_nxt;
    logic                 pressed_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= i_button;
            btn_s    <= btn_meta;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            o_pressed <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            o_pressed <= pressed_nxt;
            o_press   <= press_nxt;
            o_release <= release_nxt;
        end
    end

    // A btn_s level opposing the current state is checked before the tick,
    // so an edge coinciding with i_tick_en discards that tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a variable unassigned and infer a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = DEB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (i_tick_en) begin
                    if (cnt == DEB_LAST) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            HOLD: begin
                if (!btn_s) begin
                    state_nxt = DEB_RELEASE;
                    cnt_nxt   = '0;
                end else if ((REPEAT_EN != 0) && i_tick_en) begin
                    if (cnt == DELAY_LAST) begin
                        state_nxt = REPEAT;
                        cnt_nxt   = '0;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_nxt = DEB_RELEASE;
                    cnt_nxt   = '0;
                end else if (i_tick_en) begin
                    if (cnt == RATE_LAST) begin
                        cnt_nxt   = '0;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            DEB_RELEASE: begin
                if (btn_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else if (i_tick_en) begin
                    if (cnt == DEB_LAST) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        pressed_nxt = (state_nxt == HOLD) || (state_nxt == REPEAT) ||
                      (state_nxt == DEB_RELEASE);
    end

endmodule

// File: tb/tb_button_repeat.sv
// Directed bench for button_repeat: debounce 4 ticks, repeat delay 10,
// repeat rate 3, one tick every 4 clocks; event cycles logged and compared.
module tb_button_repeat;

    logic clk;
    logic rst_n;
    logic tick;
    logic btn;
    logic btn_nr;
    logic o_pressed, o_press, o_release;
    logic nr_pressed, nr_press, nr_release;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // event logs: cycle numbers at which each event was observed
    int press_t[64];
    int rel_t[64];
    int rise_t[64];
    int fall_t[64];
    int np_t[64];
    int nr_t[64];
    int n_press = 0, n_rel = 0, n_rise = 0, n_fall = 0, n_np = 0, n_nr = 0;
    int n_overlap = 0;
    logic prev_pressed = 1'b0;

    button_repeat #(
        .DEBOUNCE_TICKS(4), .REPEAT_DELAY(10), .REPEAT_RATE(3),
        .REPEAT_EN(1), .CNT_WIDTH(8)
    ) dut (
        .i_sysclk(clk), .i_reset_n(rst_n), .i_tick_en(tick), .i_button(btn),
        .o_pressed(o_pressed), .o_press(o_press), .o_release(o_release)
    );

    button_repeat #(
        .DEBOUNCE_TICKS(4), .REPEAT_DELAY(10), .REPEAT_RATE(3),
        .REPEAT_EN(0), .CNT_WIDTH(8)
    ) dut_nr (
        .i_sysclk(clk), .i_reset_n(rst_n), .i_tick_en(tick), .i_button(btn_nr),
        .o_pressed(nr_pressed), .o_press(nr_press), .o_release(nr_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // tick lands on every posedge whose number is a multiple of 4
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = ((cyc + 1) % 4 == 0);
        end
    end

    always @(negedge clk) begin
        if (o_press && n_press < 64) begin press_t[n_press] = cyc; n_press++; end
        if (o_release && n_rel < 64) begin rel_t[n_rel] = cyc; n_rel++; end
        if (o_pressed && !prev_pressed && n_rise < 64) begin rise_t[n_rise] = cyc; n_rise++; end
        if (!o_pressed && prev_pressed && n_fall < 64) begin fall_t[n_fall] = cyc; n_fall++; end
        prev_pressed = o_pressed;
        if (nr_press && n_np < 64) begin np_t[n_np] = cyc; n_np++; end
        if (nr_release && n_nr < 64) begin nr_t[n_nr] = cyc; n_nr++; end
        if ((o_press && o_release) || (nr_press && nr_release)) n_overlap++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic align();
        while (cyc % 4 != 0) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int c0, c1, c2, c3, c4, c5, c6;
    int bp, br, brl, bf, bnp, bnr;

    initial begin
        rst_n  = 1'b0;
        btn    = 1'b0;
        btn_nr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pressed", int'(o_pressed), 0);
        check("rst_press", int'(o_press), 0);
        check("rst_release", int'(o_release), 0);
        check("rst_nr_pressed", int'(nr_pressed), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // clean press, then repeats at +10 ticks and every 3 ticks after
        align();
        c0 = cyc; bp = n_press; br = n_rise;
        btn = 1'b1;
        wait_until(c0 + 82);
        check("t1_press_count", n_press - bp, 4);
        check("t1_press0", press_t[bp] - c0, 16);
        check("t1_repeat1", press_t[bp + 1] - c0, 56);
        check("t1_repeat2", press_t[bp + 2] - c0, 68);
        check("t1_repeat3", press_t[bp + 3] - c0, 80);
        check("t1_pressed_rise", rise_t[br] - c0, 16);

        // release with a 2-tick bounce back high
        align();
        c1 = cyc; bp = n_press; brl = n_rel; bf = n_fall;
        btn = 1'b0;
        wait_until(c1 + 6);
        btn = 1'b1;
        wait_until(c1 + 14);
        btn = 1'b0;
        wait_until(c1 + 40);
        check("t3_no_press", n_press - bp, 0);
        check("t3_release_count", n_rel - brl, 1);
        check("t3_release_at", rel_t[brl] - c1, 32);
        check("t3_fall_count", n_fall - bf, 1);
        check("t3_fall_at", fall_t[bf] - c1, 32);

        // bouncing press: 5-cycle toggles for 40 cycles, then hold
        align();
        c2 = cyc; bp = n_press; brl = n_rel;
        for (int i = 0; i < 8; i++) begin
            btn = ~i[0];
            wait_until(c2 + 5 * (i + 1));
        end
        btn = 1'b1;
        wait_until(c2 + 60);
        check("t2_press_count", n_press - bp, 1);
        check("t2_press_at", press_t[bp] - c2, 56);
        btn = 1'b0;
        wait_until(c2 + 100);
        check("t2_released", int'(o_pressed), 0);
        check("t2_release_count", n_rel - brl, 1);

        // btn_s falls on the terminal debounce tick: no press allowed
        align();
        c3 = cyc; bp = n_press;
        btn = 1'b1;
        wait_until(c3 + 13);
        btn = 1'b0;
        wait_until(c3 + 40);
        check("t6_no_press", n_press - bp, 0);
        check("t6_pressed", int'(o_pressed), 0);

        // async reset pulse while in REPEAT with the button still held
        align();
        c4 = cyc;
        btn = 1'b1;
        wait_until(c4 + 60);
        check("t5_pre_pressed", int'(o_pressed), 1);
        c5 = cyc; bp = n_press;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_pressed", int'(o_pressed), 0);
        check("t5_rst_press", int'(o_press), 0);
        check("t5_rst_release", int'(o_release), 0);
        #9 rst_n = 1'b1;
        @(negedge clk);
        wait_until(c5 + 30);
        check("t5_press_count", n_press - bp, 1);
        check("t5_press_at", press_t[bp] - c5, 20);
        btn = 1'b0;
        wait_until(c5 + 60);

        // REPEAT_EN=0: 50 ticks held gives exactly one press, one release
        align();
        c6 = cyc; bnp = n_np; bnr = n_nr;
        btn_nr = 1'b1;
        wait_until(c6 + 200);
        btn_nr = 1'b0;
        wait_until(c6 + 240);
        check("t4_press_count", n_np - bnp, 1);
        check("t4_press_at", np_t[bnp] - c6, 16);
        check("t4_release_count", n_nr - bnr, 1);
        check("t4_release_at", nr_t[bnr] - c6, 216);
        check("t4_pressed_end", int'(nr_pressed), 0);

        check("press_release_exclusive", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
